sr_bank_ctrl: RTL and testbench

// - Sequences a bank of NBIT SR flip-flops, each with inputs s/r and output q, on behalf of NREQ requesters.
// - Round-robin arbitration grants one set/clear command at a time.
// - Drives single-cycle s/r pulses that never assert S and R together, then reads back q and flags mismatches.
// - Sits between control logic and the SR bank; it is the only driver of the bank's s/r pins.

---
 rtl/sr_bank_ctrl.sv | 153 +++++++++++++++
 tb/tb_sr_bank_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin sequencer for a bank of SR flops. Each command is
// one registered s/r pulse, then a readback check of bank_q.
module sr_bank_ctrl #(
    parameter  int NREQ = 4,
    parameter  int NBIT = 8,
    localparam int IDXW = $clog2(NBIT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_set,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clr_all,
    output logic                 clr_ack,
    output logic [NBIT-1:0]      bank_s,
    output logic [NBIT-1:0]      bank_r,
    input  logic [NBIT-1:0]      bank_q,
    output logic                 busy,
    output logic                 err,
    output logic [IDXW-1:0]      err_idx,
    input  logic                 err_clr
);

    localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PTR_RST_I = NREQ - 1;
    localparam logic [PW-1:0] PTR_RST = PTR_RST_I[PW-1:0];

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic            op_set, op_clrall, op_drop;
    logic [IDXW-1:0] idx_q;

    logic            gnt_found;
    logic [PW-1:0]   gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            in_range;
    logic [NBIT-1:0] onehot;
    logic            mismatch;
    logic [IDXW-1:0] fail_idx;
    int              cand;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = ptr;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt       = cand[PW-1:0];
            end
        end
        gnt_idx  = req_idx[gnt*IDXW +: IDXW];
        in_range = {{(32-IDXW){1'b0}}, gnt_idx} < 32'(NBIT);
        onehot   = {{(NBIT-1){1'b0}}, 1'b1} << gnt_idx;

        // Grants are suppressed while in reset so nothing transfers into a dead FSM.
        clr_ack   = 1'b0;
        req_ready = '0;
        if (rst_n && state == IDLE) begin
            if (clr_all)
                clr_ack = 1'b1;
            else if (gnt_found)
                req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        mismatch = 1'b0;
        fail_idx = idx_q;
        if (state == CHECK && !op_drop) begin
            if (op_clrall) begin
                mismatch = |bank_q;
                for (int i = NBIT - 1; i >= 0; i--)
                    if (bank_q[i]) fail_idx = i[IDXW-1:0];
            end else begin
                mismatch = (bank_q[idx_q] != op_set);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            bank_s    <= '0;
            bank_r    <= '0;
            op_set    <= 1'b0;
            op_clrall <= 1'b0;
            op_drop   <= 1'b0;
            idx_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_all) begin
                        op_set    <= 1'b0;
                        op_clrall <= 1'b1;
                        op_drop   <= 1'b0;
                        bank_r    <= '1;
                        state     <= DRIVE;
                    end else if (gnt_found) begin
                        op_set    <= req_set[gnt];
                        op_clrall <= 1'b0;
                        op_drop   <= !in_range;
                        idx_q     <= gnt_idx;
                        ptr       <= gnt;
                        if (in_range) begin
                            if (req_set[gnt]) bank_s <= onehot;
                            else              bank_r <= onehot;
                        end
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    bank_s <= '0;
                    bank_r <= '0;
                    state  <= CHECK;
                end
                default: begin
                    bank_s <= '0;
                    bank_r <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // First error wins; err_clr overrides a same-cycle mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_idx <= '0;
        end else if (err_clr) begin
            err     <= 1'b0;
            err_idx <= '0;
        end else if (mismatch && !err) begin
            err     <= 1'b1;
            err_idx <= fail_idx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl: an 8-bit instance with a behavioural SR bank
// (with stuck-at-0 injection) and a 6-bit instance for out-of-range indices.
module tb_sr_bank_ctrl;

    localparam int NREQ = 4;
    localparam int NBIT = 8;
    localparam int IDXW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_set = '0;
    logic [NREQ*IDXW-1:0] req_idx = '0;
    logic clr_all = 1'b0;
    logic err_clr = 1'b0;

    logic [NREQ-1:0] req_ready, req_ready6;
    logic            clr_ack, clr_ack6;
    logic [7:0]      bank_s, bank_r, q8 = '0, stuck0 = '0;
    logic [5:0]      bank_s6, bank_r6, q6 = '0;
    logic            busy, busy6, err, err6;
    logic [2:0]      err_idx, err_idx6;
    logic [7:0]      bank_q;

    int checks = 0;
    int errors = 0;

    assign bank_q = q8 & ~stuck0;

    always #5 clk = ~clk;

    always @(posedge clk) q8 <= (q8 | bank_s) & ~bank_r;
    always @(posedge clk) q6 <= (q6 | bank_s6) & ~bank_r6;

    sr_bank_ctrl #(.NREQ(NREQ), .NBIT(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_set(req_set),
        .req_idx(req_idx), .req_ready(req_ready), .clr_all(clr_all), .clr_ack(clr_ack),
        .bank_s(bank_s), .bank_r(bank_r), .bank_q(bank_q), .busy(busy),
        .err(err), .err_idx(err_idx), .err_clr(err_clr)
    );

    sr_bank_ctrl #(.NREQ(NREQ), .NBIT(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_set(req_set),
        .req_idx(req_idx), .req_ready(req_ready6), .clr_all(clr_all), .clr_ack(clr_ack6),
        .bank_s(bank_s6), .bank_r(bank_r6), .bank_q(q6), .busy(busy6),
        .err(err6), .err_idx(err_idx6), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic s, input logic [IDXW-1:0] idx);
        req_set[i]             = s;
        req_idx[i*IDXW +: IDXW] = idx;
    endtask

    // From a granting IDLE cycle: walk DRIVE and CHECK, land in the next IDLE.
    task automatic finish_cmd();
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    // Bank pin invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("s_and_r", 32'(bank_s & bank_r), 32'd0);
            check("one_pin", 32'(($countones(bank_s | bank_r) <= 1) ||
                                 (bank_r == 8'hFF && bank_s == 8'h00)), 32'd1);
        end
    end

    initial begin
        // Reset state, with requests and clr_all pending to prove the forcing.
        req_valid = 4'b1111;
        clr_all   = 1'b1;
        #12;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_clr_ack", 32'(clr_ack), 32'd0);
        check("rst_bank_s", 32'(bank_s), 32'd0);
        check("rst_bank_r", 32'(bank_r), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_idx", 32'(err_idx), 32'd0);
        req_valid = '0;
        clr_all   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single set of flop 3 by requester 0.
        set_req(0, 1'b1, 3'd3);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        check("t1_busy_idle", 32'(busy), 32'd0);
        tick();
        check("t1_bank_s", 32'(bank_s), 32'h08);
        check("t1_bank_r", 32'(bank_r), 32'h00);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready_drive", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        check("t1_bank_s_chk", 32'(bank_s), 32'd0);
        check("t1_err_chk", 32'(err), 32'd0);
        tick();
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_err_end", 32'(err), 32'd0);

        // Fresh reset so the pointer starts at NREQ-1, then round robin.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'(i + 4));
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("rr_ready", 32'(req_ready), 32'd1 << (i % 4));
            tick();
            check("rr_bank_s", 32'(bank_s), 32'd1 << ((i % 4) + 4));
            if (i == 4) req_valid = '0;
            tick();
            tick();
        end
        check("rr_idle", 32'(busy), 32'd0);

        // clr_all beats a pending request; requester 1 wins next IDLE.
        set_req(1, 1'b1, 3'd1);
        req_valid = 4'b0010;
        clr_all   = 1'b1;
        #1;
        check("ca_ack", 32'(clr_ack), 32'd1);
        check("ca_ready", 32'(req_ready), 32'd0);
        tick();
        clr_all = 1'b0;
        check("ca_bank_r", 32'(bank_r), 32'hFF);
        check("ca_bank_s", 32'(bank_s), 32'h00);
        check("ca_ack_drive", 32'(clr_ack), 32'd0);
        tick();
        check("ca_bank_r_chk", 32'(bank_r), 32'h00);
        tick();
        check("ca_err", 32'(err), 32'd0);
        check("ca_next_ready", 32'(req_ready), 32'h2);
        finish_cmd();

        // Stuck-at-0 on flop 5: first error latched, later one ignored.
        stuck0 = 8'h20;
        set_req(0, 1'b1, 3'd5);
        req_valid = 4'b0001;
        #1;
        check("e1_ready", 32'(req_ready), 32'h1);
        finish_cmd();
        check("e1_err", 32'(err), 32'd1);
        check("e1_err_idx", 32'(err_idx), 32'd5);
        stuck0 = 8'h24;
        set_req(0, 1'b1, 3'd2);
        req_valid = 4'b0001;
        finish_cmd();
        check("e2_err", 32'(err), 32'd1);
        check("e2_err_idx", 32'(err_idx), 32'd5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("e3_err", 32'(err), 32'd0);
        check("e3_err_idx", 32'(err_idx), 32'd0);
        // err_clr coinciding with a mismatch in CHECK wins.
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("e4_err", 32'(err), 32'd0);
        check("e4_err_idx", 32'(err_idx), 32'd0);
        stuck0 = 8'h00;

        // Reset in DRIVE aborts the pulse; next grant restarts at requester 0.
        set_req(2, 1'b1, 3'd6);
        req_valid = 4'b0100;
        #1;
        check("r_ready", 32'(req_ready), 32'h4);
        tick();
        check("r_bank_s", 32'(bank_s), 32'h40);
        rst_n = 1'b0;
        #1;
        check("r_bank_s_async", 32'(bank_s), 32'd0);
        check("r_bank_r_async", 32'(bank_r), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_ready_forced", 32'(req_ready), 32'd0);
        set_req(0, 1'b0, 3'd6);
        req_valid = 4'b0101;
        tick();
        rst_n = 1'b1;
        #1;
        check("r_next_ready", 32'(req_ready), 32'h1);
        finish_cmd();
        check("r_err", 32'(err), 32'd0);

        // Out-of-range index on the 6-flop instance: granted, no pulse, no check.
        set_req(0, 1'b1, 3'd7);
        req_valid = 4'b0001;
        #1;
        check("oor_ready", 32'(req_ready6), 32'h1);
        tick();
        check("oor_bank_s", 32'(bank_s6), 32'd0);
        check("oor_bank_r", 32'(bank_r6), 32'd0);
        check("oor_busy_drive", 32'(busy6), 32'd1);
        req_valid = '0;
        tick();
        check("oor_busy_chk", 32'(busy6), 32'd1);
        tick();
        check("oor_busy_end", 32'(busy6), 32'd0);
        check("oor_err", 32'(err6), 32'd0);
        set_req(0, 1'b0, 3'd6);
        req_valid = 4'b0001;
        #1;
        check("oor2_ready", 32'(req_ready6), 32'h1);
        tick();
        check("oor2_bank_r", 32'(bank_r6), 32'd0);
        req_valid = '0;
        tick();
        tick();
        check("oor2_busy_end", 32'(busy6), 32'd0);
        check("oor2_err", 32'(err6), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
